// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 3-sample vote and FIFO; push 1 clk after stop decision, tvalid 1 clk after push, stalls on str_tready.
// Line-break detection (break flag + BRKWAIT) is built only when UART_RX_BREAK_EN is defined.
module uart_rx_ovs #(
  parameter int DW = 8,
  parameter int FD = 8,
  parameter int BL = 16,
  parameter int FL = $clog2(FD) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BL-1:0] cfg_div,
  input  logic [1:0]    cfg_prt,
  input  logic          cfg_stp,
  input  logic          uart_rxd,
  output logic          str_tvalid,
  output logic [DW-1:0] str_tdata,
  input  logic          str_tready,
  output logic          str_terror_parity,
  output logic          str_terror_frame,
  output logic          str_terror_break,
  output logic          err_overflow,
  input  logic          err_clr,
  output logic [FL-1:0] fifo_cnt,
  output logic          rx_busy
);

`ifdef UART_RX_BREAK_EN
  localparam int WW = DW + 3;
`else
  localparam int WW = DW + 2;
`endif
  localparam int AW = $clog2(FD);
  localparam logic [3:0]    LAST_BIT = 4'(DW - 1);
  localparam logic [BL-1:0] ONE      = BL'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRKWAIT
  } state_t;

  logic          sync1_q, sync2_q, prev_q;
  logic          fall;
  state_t        state_q, state_d;
  logic [BL-1:0] bc_q, bc_d, div_q, div_d;
  logic [BL-1:0] mid, mid_m1, mid_p1, bc_inc;
  logic [1:0]    smp_q, smp_d, prt_q, prt_d;
  logic          stp_q, stp_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [3:0]    nb_q, nb_d;
  logic          par_q, par_d, perr_q, perr_d, ferr_q, ferr_d;
`ifdef UART_RX_BREAK_EN
  logic          zero_q, zero_d;
`endif
  logic          push_q, push_d;
  logic [WW-1:0] word_q, word_d;
  logic          vote, dec, wrap, fin_frm, fin_brk;

  logic [WW-1:0] mem_q [FD];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [FL-1:0] cnt_q, cnt_d;
  logic [WW-1:0] head_q;
  logic          vld_q, vld_d, ovf_q;
  logic          pop, full, wr_en;

  assign fall = prev_q & ~sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    div_d   = div_q;
    prt_d   = prt_q;
    stp_d   = stp_q;
    smp_d   = smp_q;
    sh_d    = sh_q;
    nb_d    = nb_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
`ifdef UART_RX_BREAK_EN
    zero_d  = zero_q;
`endif
    push_d  = 1'b0;
    word_d  = word_q;
    fin_frm = 1'b0;
    fin_brk = 1'b0;

    mid    = div_q >> 1;
    mid_m1 = mid - ONE;
    mid_p1 = mid + ONE;
    wrap   = (bc_q == div_q);
    dec    = (bc_q == mid_p1);
    bc_inc = wrap ? '0 : bc_q + ONE;
    vote   = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);

    if (bc_q == mid_m1) smp_d[0] = sync2_q;
    if (bc_q == mid)    smp_d[1] = sync2_q;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          bc_d    = '0;
          div_d   = cfg_div;
          prt_d   = cfg_prt;
          stp_d   = cfg_stp;
          nb_d    = '0;
          par_d   = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
`ifdef UART_RX_BREAK_EN
          zero_d  = 1'b1;
`endif
        end
      end
      ST_START: begin
        bc_d = bc_inc;
        if (dec && vote) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          state_d = ST_DATA;
          nb_d    = '0;
        end
      end
      ST_DATA: begin
        bc_d = bc_inc;
        if (dec) begin
          sh_d  = {vote, sh_q[DW-1:1]};
          par_d = par_q ^ vote;
`ifdef UART_RX_BREAK_EN
          zero_d = zero_q & ~vote;
`endif
        end
        if (wrap) begin
          if (nb_q == LAST_BIT) begin
            state_d = prt_q[1] ? ST_PARITY : ST_STOP1;
          end else begin
            nb_d = nb_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        bc_d = bc_inc;
        if (dec) begin
          perr_d = (par_q ^ vote) != prt_q[0];
`ifdef UART_RX_BREAK_EN
          zero_d = zero_q & ~vote;
`endif
        end
        if (wrap) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        bc_d = bc_inc;
        if (dec) begin
`ifdef UART_RX_BREAK_EN
          if (zero_q && !vote) begin
            push_d  = 1'b1;
            fin_frm = 1'b1;
            fin_brk = 1'b1;
            bc_d    = '0;
            state_d = ST_BRKWAIT;
          end else
`endif
          if (stp_q) begin
            ferr_d = ~vote;
          end else begin
            // Ending here rather than at the wrap lets an early start edge resync.
            push_d  = 1'b1;
            fin_frm = ~vote;
            state_d = ST_IDLE;
          end
        end else if (wrap) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        bc_d = bc_inc;
        if (dec) begin
          push_d  = 1'b1;
          fin_frm = ferr_q | ~vote;
          state_d = ST_IDLE;
        end
      end
`ifdef UART_RX_BREAK_EN
      ST_BRKWAIT: begin
        if (!sync2_q) begin
          bc_d = '0;
        end else if (wrap) begin
          state_d = ST_IDLE;
        end else begin
          bc_d = bc_q + ONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef UART_RX_BREAK_EN
    if (push_d) word_d = {fin_brk, fin_frm, perr_q, sh_q};
`else
    if (push_d) word_d = {fin_frm, perr_q, sh_q};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bc_q    <= '0;
      div_q   <= '0;
      prt_q   <= '0;
      stp_q   <= 1'b0;
      smp_q   <= 2'b11;
      sh_q    <= '0;
      nb_q    <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_BREAK_EN
      zero_q  <= 1'b0;
`endif
      push_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      div_q   <= div_d;
      prt_q   <= prt_d;
      stp_q   <= stp_d;
      smp_q   <= smp_d;
      sh_q    <= sh_d;
      nb_q    <= nb_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_BREAK_EN
      zero_q  <= zero_d;
`endif
      push_q  <= push_d;
      word_q  <= word_d;
    end
  end

  // Head is only refreshed from words already stored before this edge, so a
  // push into an empty FIFO shows up one cycle after fifo_cnt moves.
  always_comb begin
    pop      = vld_q & str_tready;
    full     = (cnt_q == FL'(FD));
    wr_en    = push_q & (~full | pop);
    cnt_d    = cnt_q + FL'(wr_en) - FL'(pop);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    vld_d    = (cnt_q - FL'(pop)) != '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= word_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      if (vld_d) head_q <= mem_q[rd_ptr_d];
      if (err_clr) begin
        ovf_q <= 1'b0;
      end else if (push_q && full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign str_tvalid        = vld_q;
  assign str_tdata         = head_q[DW-1:0];
  assign str_terror_parity = head_q[DW];
  assign str_terror_frame  = head_q[DW+1];
`ifdef UART_RX_BREAK_EN
  assign str_terror_break  = head_q[DW+2];
`else
  assign str_terror_break  = 1'b0;
`endif
  assign err_overflow      = ovf_q;
  assign fifo_cnt          = cnt_q;
  assign rx_busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed and randomized frames for uart_rx_ovs, checked against a frame-level model.
module tb_uart_rx_ovs;
  localparam int DW = 8;
  localparam int FD = 4;
  localparam int BL = 16;
  localparam int FL = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [BL-1:0] cfg_div;
  logic [1:0]    cfg_prt;
  logic          cfg_stp;
  logic          uart_rxd;
  logic          str_tvalid;
  logic [DW-1:0] str_tdata;
  logic          str_tready;
  logic          str_terror_parity;
  logic          str_terror_frame;
  logic          str_terror_break;
  logic          err_overflow;
  logic          err_clr;
  logic [FL-1:0] fifo_cnt;
  logic          rx_busy;

  uart_rx_ovs #(.DW(DW), .FD(FD), .BL(BL)) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_div           (cfg_div),
    .cfg_prt           (cfg_prt),
    .cfg_stp           (cfg_stp),
    .uart_rxd          (uart_rxd),
    .str_tvalid        (str_tvalid),
    .str_tdata         (str_tdata),
    .str_tready        (str_tready),
    .str_terror_parity (str_terror_parity),
    .str_terror_frame  (str_terror_frame),
    .str_terror_break  (str_terror_break),
    .err_overflow      (err_overflow),
    .err_clr           (err_clr),
    .fifo_cnt          (fifo_cnt),
    .rx_busy           (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t0 = 0;
  int rise_cyc = -1;
  bit vld_prev = 1'b0;
  bit busy_seen = 1'b0;
  logic [10:0] got[$];

  // Monitor: records every accepted word as {break, frame, parity, data}.
  always begin
    @(negedge clk);
    #2;
    if (str_tvalid && !vld_prev) rise_cyc = cyc;
    vld_prev = str_tvalid;
    if (rx_busy) busy_seen = 1'b1;
    if (str_tvalid && str_tready)
      got.push_back({str_terror_break, str_terror_frame, str_terror_parity, str_tdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected word from the frame as driven on the line.
  function automatic logic [10:0] model(input logic [7:0] d, input logic [1:0] prt, input logic pb,
                                        input logic stp, input logic s1, input logic s2);
    logic pe, fe, br;
    pe = prt[1] && ((^d ^ pb) != prt[0]);
    fe = !s1 || (stp && !s2);
`ifdef UART_RX_BREAK_EN
    br = (d == 8'h00) && (!prt[1] || !pb) && !s1;
`else
    br = 1'b0;
`endif
    return {br, fe, pe, d};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic [1:0] prt, input logic pb,
                            input logic stp, input logic s1, input logic s2,
                            input int div, input bit scramble);
    cfg_div = 16'(div);
    cfg_prt = prt;
    cfg_stp = stp;
    @(negedge clk);
    t0 = cyc;
    uart_rxd = 1'b0;
    repeat (div + 1) @(negedge clk);
    if (scramble) begin
      cfg_div = 16'($urandom_range(3, 40));
      cfg_prt = 2'($urandom);
      cfg_stp = 1'($urandom);
    end
    for (int i = 0; i < DW; i++) begin
      uart_rxd = d[i];
      repeat (div + 1) @(negedge clk);
    end
    if (prt[1]) begin
      uart_rxd = pb;
      repeat (div + 1) @(negedge clk);
    end
    uart_rxd = s1;
    repeat (div + 1) @(negedge clk);
    if (stp) begin
      uart_rxd = s2;
      repeat (div + 1) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (2 * (div + 1) + 6) @(negedge clk);
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(got.size() >= n), 32'(1));
  endtask

  task automatic chk_word(input string tag, input logic [10:0] exp);
    logic [10:0] w = 'x;
    if (got.size() != 0) w = got.pop_front();
    chk(tag, 32'(w), 32'(exp));
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] prt;
    logic pb, stp, s1, s2;
    int div;

    rst = 1'b1; uart_rxd = 1'b1; str_tready = 1'b1; err_clr = 1'b0;
    cfg_div = 16'd15; cfg_prt = 2'd0; cfg_stp = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 32'(str_tvalid), 32'(0));
    chk("rst_tdata", 32'(str_tdata), 32'(0));
    chk("rst_flags", 32'({str_terror_break, str_terror_frame, str_terror_parity}), 32'(0));
    chk("rst_ovf", 32'(err_overflow), 32'(0));
    chk("rst_cnt", 32'(fifo_cnt), 32'(0));
    chk("rst_busy", 32'(rx_busy), 32'(0));

    // 0xA5 8N1, div 15: STOP1 decision 3+9*16+(7+1)+1 clocks after the line edge, tvalid 2 later.
    rise_cyc = -1;
    send_frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 15, 1'b0);
    chk("a5_rise", 32'(rise_cyc - t0), 32'(3 + 9 * 16 + 8 + 1 + 2));
    wait_words(1, 50, "a5_timeout");
    chk_word("a5_word", 11'h0A5);
    chk("a5_cnt", 32'(fifo_cnt), 32'(0));

    send_frame(8'h3C, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 15, 1'b0);
    send_frame(8'h3C, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 15, 1'b0);
    wait_words(2, 50, "par_timeout");
    chk_word("par_even", model(8'h3C, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1));
    chk_word("par_odd", model(8'h3C, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1));

    busy_seen = 1'b0;
    cfg_div = 16'd15; cfg_prt = 2'd0;
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_seen", 32'(busy_seen), 32'(1));
    chk("glitch_busy", 32'(rx_busy), 32'(0));
    chk("glitch_cnt", 32'(fifo_cnt), 32'(0));
    chk("glitch_words", 32'(got.size()), 32'(0));

    str_tready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 7, 1'b0);
    chk("ovf_cnt", 32'(fifo_cnt), 32'(FD));
    chk("ovf_flag", 32'(err_overflow), 32'(1));
    chk("ovf_vld", 32'(str_tvalid), 32'(1));
    chk("ovf_head", 32'(str_tdata), 32'(1));
    str_tready = 1'b1;
    wait_words(4, 20, "ovf_timeout");
    for (int i = 1; i <= 4; i++) chk_word("ovf_order", 11'(i));
    repeat (5) @(negedge clk);
    chk("ovf_dropped", 32'(got.size()), 32'(0));
    chk("ovf_cnt0", 32'(fifo_cnt), 32'(0));
    chk("ovf_sticky", 32'(err_overflow), 32'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovf_clr", 32'(err_overflow), 32'(0));

    send_frame(8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 15, 1'b0);
    send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 15, 1'b0);
    wait_words(2, 50, "frm_timeout");
    chk_word("frm_bad", 11'h25A);
    chk_word("frm_next", 11'h011);

    // Reset mid-frame with one word queued.
    str_tready = 1'b0;
    send_frame(8'h77, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 7, 1'b0);
    chk("mrst_pre", 32'(fifo_cnt), 32'(1));
    uart_rxd = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; uart_rxd = 1'b1;
    chk("mrst_busy", 32'(rx_busy), 32'(0));
    chk("mrst_cnt", 32'(fifo_cnt), 32'(0));
    chk("mrst_vld", 32'(str_tvalid), 32'(0));
    repeat (40) @(negedge clk);
    str_tready = 1'b1;
    repeat (10) @(negedge clk);
    chk("mrst_words", 32'(got.size()), 32'(0));

    // Line held low for 20 bit periods at div 7.
    cfg_div = 16'd7; cfg_prt = 2'd0; cfg_stp = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (160) @(negedge clk);
`ifdef UART_RX_BREAK_EN
    chk("brk_busy_low", 32'(rx_busy), 32'(1));
`else
    chk("brk_busy_low", 32'(rx_busy), 32'(0));
`endif
    uart_rxd = 1'b1;
    repeat (8) @(negedge clk);
`ifdef UART_RX_BREAK_EN
    chk("brk_busy_hold", 32'(rx_busy), 32'(1));
`endif
    repeat (6) @(negedge clk);
    chk("brk_busy_end", 32'(rx_busy), 32'(0));
    repeat (20) @(negedge clk);
    chk("brk_count", 32'(got.size()), 32'(1));
    chk_word("brk_word", model(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));

    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d = 8'h00;
      prt = 2'($urandom);
      stp = 1'($urandom);
      div = $urandom_range(3, 20);
      pb  = (^d) ^ prt[0];
      if ($urandom_range(0, 2) == 0) pb = ~pb;
      s1  = ($urandom_range(0, 3) != 0);
      s2  = ($urandom_range(0, 3) != 0);
      send_frame(d, prt, pb, stp, s1, s2, div, 1'b1);
      wait_words(1, 50, "rnd_timeout");
      chk_word("rnd_word", model(d, prt, pb, stp, s1, s2));
    end
    chk("end_cnt", 32'(fifo_cnt), 32'(0));
    chk("end_words", 32'(got.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
